// File: rtl/spi_flash_rd_seq.sv
// spi_flash_rd_seq
//
// Purpose:
//   Wishbone master sequencer that runs a complete SPI flash read through
//   the SPI core wrapper's register file. The transaction is the opcode,
//   a 24-bit address and N data bytes. One command is accepted on a
//   valid/ready port. Read bytes leave on a valid/ready byte stream.
//
// Ports:
//   wb_clk_i, wb_rst_i         clock, asynchronous active-high reset
//   cmd_valid_i / cmd_ready_o  command handshake (ready only in IDLE)
//   cmd_opcode_i, cmd_addr_i   flash opcode and byte address
//   cmd_len_i                  data bytes to read (0 = header only)
//   rd_valid_o / rd_ready_i    read-byte stream handshake
//   rd_data_o, rd_last_o       read byte, final-byte marker
//   done_o, err_o              end-of-command pulse, abort-by-bus-error pulse
//   wb_*                       classic-cycle Wishbone master to the SPI core
module spi_flash_rd_seq #(
    parameter logic [15:0] DIVIDER = 16'd1,
    parameter int unsigned LEN_W   = 16
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic [7:0]       cmd_opcode_i,
    input  logic [23:0]      cmd_addr_i,
    input  logic [LEN_W-1:0] cmd_len_i,
    output logic             rd_valid_o,
    input  logic             rd_ready_i,
    output logic [7:0]       rd_data_o,
    output logic             rd_last_o,
    output logic             done_o,
    output logic             err_o,
    output logic [2:0]       wb_adr_o,
    output logic [31:0]      wb_dat_o,
    output logic [3:0]       wb_sel_o,
    output logic             wb_we_o,
    output logic             wb_cyc_o,
    output logic             wb_stb_o,
    input  logic [31:0]      wb_dat_i,
    input  logic             wb_ack_i,
    input  logic             wb_err_i
);

    // Register word addresses inside the SPI core wrapper
    localparam logic [2:0]  ADR_TX0  = 3'd0;
    localparam logic [2:0]  ADR_CTRL = 3'd4;
    localparam logic [2:0]  ADR_DIV  = 3'd5;
    localparam logic [2:0]  ADR_SS   = 3'd6;
    // CTRL values: Tx_NEG | GO | CHAR_LEN (32 bits for the header, 8 per data byte)
    localparam logic [31:0] CTRL_GO_HDR  = 32'h0000_0520;
    localparam logic [31:0] CTRL_GO_BYTE = 32'h0000_0508;

    typedef enum logic [3:0] {
        S_IDLE, S_WR_DIV, S_WR_SS, S_WR_HDR, S_GO_HDR, S_POLL_HDR,
        S_WR_DUMMY, S_GO_BYTE, S_POLL_BYTE, S_RD_RX, S_OUT, S_SS_OFF, S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic               cyc_q, cyc_d;
    logic [7:0]         opcode_q, opcode_d;
    logic [23:0]        addr_q, addr_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic [7:0]         rd_data_q, rd_data_d;
    logic               err_flag_q, err_flag_d;

    // Only the GO/busy bit and the RX byte are consumed from read data
    logic unused_dat_bits;
    assign unused_dat_bits = ^wb_dat_i[31:9];

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q    <= S_IDLE;
            cyc_q      <= 1'b0;
            opcode_q   <= '0;
            addr_q     <= '0;
            cnt_q      <= '0;
            rd_data_q  <= '0;
            err_flag_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cyc_q      <= cyc_d;
            opcode_q   <= opcode_d;
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            rd_data_q  <= rd_data_d;
            err_flag_q <= err_flag_d;
        end
    end

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        cyc_d      = cyc_q;
        opcode_d   = opcode_q;
        addr_d     = addr_q;
        cnt_d      = cnt_q;
        rd_data_d  = rd_data_q;
        err_flag_d = err_flag_q;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid_i) begin
                    opcode_d   = cmd_opcode_i;
                    addr_d     = cmd_addr_i;
                    cnt_d      = cmd_len_i;
                    err_flag_d = 1'b0;
                    cyc_d      = 1'b1;      // first strobe the cycle after accept
                    state_d    = S_WR_DIV;
                end
            end
            S_OUT: begin
                if (rd_ready_i) begin
                    cnt_d   = cnt_q - LEN_W'(1);
                    state_d = (cnt_q == LEN_W'(1)) ? S_SS_OFF : S_WR_DUMMY;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: begin
                // Bus-access states: a dropped strobe re-issues one cycle later,
                // which guarantees the idle gap between accesses.
                if (!cyc_q) begin
                    cyc_d = 1'b1;
                end else if (wb_err_i) begin
                    // Error wins over ack; SS is always released once
                    cyc_d      = 1'b0;
                    err_flag_d = 1'b1;
                    state_d    = (state_q == S_SS_OFF) ? S_DONE : S_SS_OFF;
                end else if (wb_ack_i) begin
                    cyc_d = 1'b0;
                    case (state_q)
                        S_WR_DIV:    state_d = S_WR_SS;
                        S_WR_SS:     state_d = S_WR_HDR;
                        S_WR_HDR:    state_d = S_GO_HDR;
                        S_GO_HDR:    state_d = S_POLL_HDR;
                        S_POLL_HDR: begin
                            if (!wb_dat_i[8]) begin
                                state_d = (cnt_q == '0) ? S_SS_OFF : S_WR_DUMMY;
                            end
                        end
                        S_WR_DUMMY:  state_d = S_GO_BYTE;
                        S_GO_BYTE:   state_d = S_POLL_BYTE;
                        S_POLL_BYTE: begin
                            if (!wb_dat_i[8]) begin
                                state_d = S_RD_RX;
                            end
                        end
                        S_RD_RX: begin
                            rd_data_d = wb_dat_i[7:0];
                            state_d   = S_OUT;
                        end
                        S_SS_OFF:    state_d = S_DONE;
                        default:     state_d = S_IDLE;
                    endcase
                end
            end
        endcase
    end

    // Outputs decode from registered state only
    always_comb begin
        wb_adr_o = ADR_TX0;
        wb_dat_o = 32'h0;
        wb_we_o  = 1'b0;
        case (state_q)
            S_WR_DIV: begin
                wb_adr_o = ADR_DIV;
                wb_dat_o = {16'h0, DIVIDER};
                wb_we_o  = 1'b1;
            end
            S_WR_SS: begin
                wb_adr_o = ADR_SS;
                wb_dat_o = 32'h1;
                wb_we_o  = 1'b1;
            end
            S_WR_HDR: begin
                wb_adr_o = ADR_TX0;
                wb_dat_o = {opcode_q, addr_q};
                wb_we_o  = 1'b1;
            end
            S_GO_HDR: begin
                wb_adr_o = ADR_CTRL;
                wb_dat_o = CTRL_GO_HDR;
                wb_we_o  = 1'b1;
            end
            S_POLL_HDR, S_POLL_BYTE: wb_adr_o = ADR_CTRL;
            S_WR_DUMMY: begin
                wb_adr_o = ADR_TX0;
                wb_we_o  = 1'b1;
            end
            S_GO_BYTE: begin
                wb_adr_o = ADR_CTRL;
                wb_dat_o = CTRL_GO_BYTE;
                wb_we_o  = 1'b1;
            end
            S_RD_RX: wb_adr_o = ADR_TX0;
            S_SS_OFF: begin
                wb_adr_o = ADR_SS;
                wb_we_o  = 1'b1;
            end
            default: ;
        endcase

        wb_cyc_o    = cyc_q;
        wb_stb_o    = cyc_q;
        wb_sel_o    = 4'hF;
        cmd_ready_o = (state_q == S_IDLE);
        rd_valid_o  = (state_q == S_OUT);
        rd_data_o   = rd_data_q;
        rd_last_o   = (state_q == S_OUT) && (cnt_q == LEN_W'(1));
        done_o      = (state_q == S_DONE);
        err_o       = (state_q == S_DONE) && err_flag_q;
    end

endmodule

// File: tb/tb_spi_flash_rd_seq.sv
// tb_spi_flash_rd_seq
//
// Purpose: self-checking bench for spi_flash_rd_seq. A behavioural SPI-core
// register slave answers the Wishbone accesses and supplies flash bytes.
// Each command's expected access list and byte stream are built from the
// sequencing rules and compared after the command completes.
module tb_spi_flash_rd_seq;

    localparam int LEN_W     = 16;
    localparam int STALL_LEN = 20;
    localparam int BUDGET    = 20000;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             cmd_valid_i = 1'b0;
    logic             cmd_ready_o;
    logic [7:0]       cmd_opcode_i = '0;
    logic [23:0]      cmd_addr_i = '0;
    logic [LEN_W-1:0] cmd_len_i = '0;
    logic             rd_valid_o;
    logic             rd_ready_i = 1'b0;
    logic [7:0]       rd_data_o;
    logic             rd_last_o;
    logic             done_o;
    logic             err_o;
    logic [2:0]       wb_adr_o;
    logic [31:0]      wb_dat_o;
    logic [3:0]       wb_sel_o;
    logic             wb_we_o;
    logic             wb_cyc_o;
    logic             wb_stb_o;
    logic [31:0]      wb_dat_i = '0;
    logic             wb_ack_i = 1'b0;
    logic             wb_err_i = 1'b0;

    always #5 clk = ~clk;

    spi_flash_rd_seq #(.DIVIDER(16'd1), .LEN_W(LEN_W)) dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst),
        .cmd_valid_i (cmd_valid_i),
        .cmd_ready_o (cmd_ready_o),
        .cmd_opcode_i(cmd_opcode_i),
        .cmd_addr_i  (cmd_addr_i),
        .cmd_len_i   (cmd_len_i),
        .rd_valid_o  (rd_valid_o),
        .rd_ready_i  (rd_ready_i),
        .rd_data_o   (rd_data_o),
        .rd_last_o   (rd_last_o),
        .done_o      (done_o),
        .err_o       (err_o),
        .wb_adr_o    (wb_adr_o),
        .wb_dat_o    (wb_dat_o),
        .wb_sel_o    (wb_sel_o),
        .wb_we_o     (wb_we_o),
        .wb_cyc_o    (wb_cyc_o),
        .wb_stb_o    (wb_stb_o),
        .wb_dat_i    (wb_dat_i),
        .wb_ack_i    (wb_ack_i),
        .wb_err_i    (wb_err_i)
    );

    typedef struct packed {
        logic        we;
        logic [2:0]  adr;
        logic [31:0] dat;
    } acc_t;

    acc_t       obs_q[$];
    acc_t       exp_q[$];
    logic [7:0] flash_q[$];
    logic [7:0] exp_bytes_q[$];
    logic [7:0] preset_q[$];
    logic [7:0] got_q[$];
    logic       got_last_q[$];

    int checks = 0;
    int errors = 0;

    // Slave / consumer knobs
    int ack_delay = 0, busy_polls = 0, err_go_n = 0, stall_byte = 0;
    bit err_ss_off = 0, err_with_ack = 0, rand_ready = 0;
    // Slave / consumer state
    int   wait_cnt = 0, busy_left = 0, go_byte_cnt = 0, stab_errs = 0;
    int   stall_left = 0, stall_errs = 0;
    bit   in_acc = 0, stall_started = 0;
    acc_t cur;
    logic [7:0] rx_reg = '0, stall_data = '0;
    int   done_cnt = 0, err_cnt = 0, pulse_bad = 0;
    int   exp_nbytes = 0;
    bit   exp_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // SPI core register slave: answers on the falling edge, holds the
    // termination for exactly one rising edge.
    always @(negedge clk) begin
        logic [31:0] d;
        if (rst) begin
            wb_ack_i = 1'b0;
            wb_err_i = 1'b0;
            in_acc   = 0;
            wait_cnt = 0;
            busy_left = 0;
        end else if (wb_ack_i || wb_err_i) begin
            wb_ack_i = 1'b0;
            wb_err_i = 1'b0;
            wb_dat_i = $urandom;
            in_acc   = 0;
        end else if (wb_cyc_o && wb_stb_o) begin
            if (!in_acc) begin
                in_acc   = 1;
                wait_cnt = 0;
                cur.we   = wb_we_o;
                cur.adr  = wb_adr_o;
                cur.dat  = wb_dat_o;
            end else if ({wb_we_o, wb_adr_o, wb_dat_o} !== cur) begin
                stab_errs++;
            end
            if (wait_cnt < ack_delay) begin
                wait_cnt++;
            end else begin
                obs_q.push_back(cur);
                if (cur.we && cur.adr == 3'd4 && cur.dat == 32'h508) go_byte_cnt++;
                if ((cur.we && cur.adr == 3'd4 && cur.dat == 32'h508 && go_byte_cnt == err_go_n) ||
                    (err_ss_off && cur.we && cur.adr == 3'd6 && cur.dat == 32'h0)) begin
                    wb_err_i = 1'b1;
                    wb_ack_i = err_with_ack;
                end else begin
                    wb_ack_i = 1'b1;
                    if (cur.we) begin
                        if (cur.adr == 3'd4 && cur.dat[8]) begin
                            busy_left = busy_polls;
                            if (cur.dat[6:0] == 7'd8)
                                rx_reg = (flash_q.size() > 0) ? flash_q.pop_front() : 8'hEE;
                        end
                    end else if (cur.adr == 3'd4) begin
                        d = $urandom;
                        d[8] = (busy_left > 0);
                        if (busy_left > 0) busy_left--;
                        wb_dat_i = d;
                    end else begin
                        d = $urandom;
                        d[7:0] = rx_reg;
                        wb_dat_i = d;
                    end
                end
            end
        end
    end

    // Byte consumer: decides rd_ready_i for the coming rising edge and
    // records the byte that edge will transfer.
    always @(negedge clk) begin
        if (rst) begin
            rd_ready_i = 1'b0;
            stall_left = 0;
        end else begin
            if (stall_left > 0) begin
                if (!rd_valid_o || rd_data_o !== stall_data || wb_cyc_o) stall_errs++;
                stall_left--;
            end else if (rd_valid_o && !stall_started && stall_byte == got_q.size() + 1) begin
                stall_started = 1;
                stall_left    = STALL_LEN;
                stall_data    = rd_data_o;
            end
            rd_ready_i = (stall_left > 0) ? 1'b0 : (rand_ready ? 1'($urandom_range(0, 1)) : 1'b1);
            if (rd_valid_o && rd_ready_i) begin
                got_q.push_back(rd_data_o);
                got_last_q.push_back(rd_last_o);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (done_o) done_cnt++;
            if (err_o) err_cnt++;
            if (err_o && !done_o) pulse_bad++;
        end
    end

    function automatic void push_exp(input logic we, input logic [2:0] adr, input logic [31:0] dat);
        acc_t a;
        a.we  = we;
        a.adr = adr;
        a.dat = dat;
        exp_q.push_back(a);
    endfunction

    // Reference: the register-access script a flash read must produce
    function automatic void build_expected(input logic [7:0] op, input logic [23:0] addr, input int len);
        exp_q.delete();
        exp_bytes_q.delete();
        push_exp(1'b1, 3'd5, 32'h0000_0001);
        push_exp(1'b1, 3'd6, 32'h0000_0001);
        push_exp(1'b1, 3'd0, {op, addr});
        push_exp(1'b1, 3'd4, 32'h0000_0520);
        repeat (busy_polls + 1) push_exp(1'b0, 3'd4, 32'h0);
        exp_nbytes = len;
        for (int i = 0; i < len; i++) begin
            push_exp(1'b1, 3'd0, 32'h0);
            push_exp(1'b1, 3'd4, 32'h0000_0508);
            if (i + 1 == err_go_n) begin
                exp_nbytes = i;
                break;
            end
            repeat (busy_polls + 1) push_exp(1'b0, 3'd4, 32'h0);
            push_exp(1'b0, 3'd0, 32'h0);
        end
        push_exp(1'b1, 3'd6, 32'h0);
        for (int i = 0; i < exp_nbytes; i++) exp_bytes_q.push_back(flash_q[i]);
        exp_err = (exp_nbytes < len) || err_ss_off;
    endfunction

    task automatic set_knobs(input int dly, input int busy, input int errgo, input bit errss,
                             input bit both, input int stallb, input bit rnd);
        ack_delay    = dly;
        busy_polls   = busy;
        err_go_n     = errgo;
        err_ss_off   = errss;
        err_with_ack = both;
        stall_byte   = stallb;
        rand_ready   = rnd;
    endtask

    task automatic issue_cmd(input logic [7:0] op, input logic [23:0] addr, input int len);
        obs_q.delete();
        got_q.delete();
        got_last_q.delete();
        flash_q.delete();
        go_byte_cnt = 0; stab_errs = 0; stall_errs = 0; stall_started = 0;
        done_cnt = 0; err_cnt = 0; pulse_bad = 0;
        for (int i = 0; i < len; i++)
            flash_q.push_back((preset_q.size() > 0) ? preset_q.pop_front() : 8'($urandom));
        preset_q.delete();
        build_expected(op, addr, len);
        @(negedge clk);
        cmd_valid_i  = 1'b1;
        cmd_opcode_i = op;
        cmd_addr_i   = addr;
        cmd_len_i    = LEN_W'(len);
        @(negedge clk);
        check("accept_stb", 32'(wb_stb_o), 32'd1);
        check("accept_ready_low", 32'(cmd_ready_o), 32'd0);
        // Keep valid high with new fields: they must be ignored while busy
        cmd_opcode_i = 8'($urandom);
        cmd_addr_i   = 24'($urandom);
        cmd_len_i    = LEN_W'($urandom_range(1, 7));
    endtask

    task automatic finish_cmd(input int len);
        int n = 0;
        while (!done_o && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        cmd_valid_i = 1'b0;
        check("done_timeout", 32'(n < BUDGET), 32'd1);
        @(negedge clk);
        check("ready_after_done", 32'(cmd_ready_o), 32'd1);
        check("done_one_cycle", 32'(done_o), 32'd0);
        check("n_access", obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            check("acc_we_adr", {28'h0, obs_q[i].we, obs_q[i].adr}, {28'h0, exp_q[i].we, exp_q[i].adr});
            if (exp_q[i].we) check("acc_wdata", obs_q[i].dat, exp_q[i].dat);
        end
        check("n_bytes", got_q.size(), exp_nbytes);
        for (int i = 0; i < exp_nbytes && i < got_q.size(); i++) begin
            check("byte", 32'(got_q[i]), 32'(exp_bytes_q[i]));
            check("last", 32'(got_last_q[i]), 32'(i == len - 1));
        end
        check("done_count", done_cnt, 1);
        check("err_count", err_cnt, 32'(exp_err));
        check("err_without_done", pulse_bad, 0);
        check("strobe_stable", stab_errs, 0);
        if (stall_byte > 0 && stall_byte <= exp_nbytes) begin
            check("stall_seen", 32'(stall_started), 32'd1);
            check("stall_stable", stall_errs, 0);
        end
    endtask

    initial begin
        int n;
        // Reset values
        repeat (3) @(negedge clk);
        check("rst_cmd_ready", 32'(cmd_ready_o), 32'd1);
        check("rst_rd_valid", 32'(rd_valid_o), 32'd0);
        check("rst_rd_last", 32'(rd_last_o), 32'd0);
        check("rst_rd_data", 32'(rd_data_o), 32'd0);
        check("rst_done", 32'(done_o), 32'd0);
        check("rst_err", 32'(err_o), 32'd0);
        check("rst_cyc", 32'(wb_cyc_o), 32'd0);
        check("rst_stb", 32'(wb_stb_o), 32'd0);
        check("rst_we", 32'(wb_we_o), 32'd0);
        check("rst_adr", 32'(wb_adr_o), 32'd0);
        check("rst_dat", wb_dat_o, 32'd0);
        check("sel_const", 32'(wb_sel_o), 32'hF);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Basic 3-byte read with known flash data
        preset_q = '{8'hA1, 8'hB2, 8'hC3};
        set_knobs(0, 1, 0, 0, 0, 0, 0);
        issue_cmd(8'h03, 24'h012345, 3);
        finish_cmd(3);

        // Header only
        set_knobs(1, 2, 0, 0, 0, 0, 0);
        issue_cmd(8'h03, 24'h000100, 0);
        finish_cmd(0);

        // Consumer stalls on the second byte
        set_knobs(0, 0, 0, 0, 0, 2, 0);
        issue_cmd(8'h0B, 24'h7FFFFF, 3);
        finish_cmd(3);

        // Bus error (with ack also high) on the second GO_BYTE write
        set_knobs(0, 1, 2, 0, 1, 0, 0);
        issue_cmd(8'h03, 24'h001000, 3);
        finish_cmd(3);

        // Slow slave: 5-cycle ack delay, busy for 4 polls
        set_knobs(5, 4, 0, 0, 0, 0, 1);
        issue_cmd(8'h03, 24'hFEDCBA, 2);
        finish_cmd(2);

        // Bus error on the final SS release
        set_knobs(0, 0, 0, 1, 0, 0, 0);
        issue_cmd(8'h03, 24'h000042, 1);
        finish_cmd(1);

        // Reset while polling for a data byte
        set_knobs(1, 8, 0, 0, 0, 0, 0);
        issue_cmd(8'h0B, 24'hABCDEF, 3);
        n = 0;
        while (!(go_byte_cnt >= 1 && wb_cyc_o && !wb_we_o && wb_adr_o == 3'd4) && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        check("reach_poll_byte", 32'(n < BUDGET), 32'd1);
        #2;
        rst = 1'b1;
        cmd_valid_i = 1'b0;
        #1;
        check("midrst_cyc", 32'(wb_cyc_o), 32'd0);
        check("midrst_stb", 32'(wb_stb_o), 32'd0);
        check("midrst_rd_valid", 32'(rd_valid_o), 32'd0);
        check("midrst_cmd_ready", 32'(cmd_ready_o), 32'd1);
        check("midrst_rd_data", 32'(rd_data_o), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        set_knobs(0, 1, 0, 0, 0, 0, 1);
        issue_cmd(8'h03, 24'h000200, 2);
        finish_cmd(2);

        // Randomized commands
        for (int k = 0; k < 6; k++) begin
            int len;
            len = $urandom_range(0, 4);
            set_knobs($urandom_range(0, 3), $urandom_range(0, 3), 0, 0, 0, 0, 1);
            issue_cmd(8'($urandom), 24'($urandom), len);
            finish_cmd(len);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
